// File: rtl/tg68k_cache_fill_ctrl.sv
// Cache line-fill sequencer/arbiter: grants I or D fills, reads 8 words, assembles a 128-bit line.
// Optional CACHE_FILL_WRAP_EN selects critical-word-first ordering (start word = addr[3:1]).
module tg68k_cache_fill_ctrl #(
  parameter int unsigned D_PRIORITY  = 1,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         i_fill_req,
  input  logic [31:0]  i_fill_addr,
  input  logic         d_fill_req,
  input  logic [31:0]  d_fill_addr,
  input  logic         cacr_ibe,
  input  logic         cacr_dbe,
  output logic         mem_req,
  output logic [31:0]  mem_addr,
  output logic         mem_burst,
  output logic [2:0]   mem_burst_len,
  input  logic [15:0]  mem_data,
  input  logic         mem_ack,
  output logic [127:0] fill_data,
  output logic         i_fill_valid,
  output logic         d_fill_valid,
  output logic         fill_busy,
  output logic         fill_err
);

  typedef enum logic [2:0] {StIdle, StFetch, StGap, StDone, StErr} state_e;

  localparam bit         PrefD  = (D_PRIORITY != 0);
  localparam bit         TmoEn  = (TIMEOUT_CYC != 0);
  localparam logic [7:0] TmoLim = 8'(TIMEOUT_CYC);

  state_e         state_q;
  logic [27:0]    line_q;
  logic [2:0]     idx_q;
  logic [2:0]     cnt_q;
  logic [7:0]     tmo_q;
  logic [1:0]     starve_q;
  logic           win_d_q;
  logic           mem_req_q;
  logic [31:0]    mem_addr_q;
  logic           mem_burst_q;
  logic [2:0]     mem_len_q;
  logic [127:0]   fill_q;
  logic           i_valid_q;
  logic           d_valid_q;
  logic           busy_q;
  logic           err_q;

  logic           pref_req;
  logic           oth_req;
  logic           grant_pref;
  logic           grant_d;
  logic [31:0]    g_addr;
  logic           g_burst;
  logic [2:0]     g_start;
  logic           ack;
  logic [2:0]     nxt_idx;
  logic           unused_addr_bits;

  assign unused_addr_bits = ^{i_fill_addr[3:0], d_fill_addr[3:0]};

  // After two back-to-back preferred grants that starved the other side, the other side wins.
  always_comb begin
    pref_req   = PrefD ? d_fill_req : i_fill_req;
    oth_req    = PrefD ? i_fill_req : d_fill_req;
    grant_pref = pref_req && !(oth_req && (starve_q == 2'd2));
    grant_d    = PrefD ? grant_pref : !grant_pref;
    g_addr     = grant_d ? d_fill_addr : i_fill_addr;
    g_burst    = grant_d ? cacr_dbe : cacr_ibe;
`ifdef CACHE_FILL_WRAP_EN
    g_start    = g_addr[3:1];
`else
    g_start    = 3'd0;
`endif
  end

  assign ack     = mem_ack && mem_req_q && (state_q == StFetch);
  assign nxt_idx = idx_q + 3'd1;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q     <= StIdle;
      line_q      <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      starve_q    <= '0;
      win_d_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_burst_q <= 1'b0;
      mem_len_q   <= '0;
      fill_q      <= '0;
      i_valid_q   <= 1'b0;
      d_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      err_q     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_fill_req || d_fill_req) begin
            state_q     <= StFetch;
            busy_q      <= 1'b1;
            mem_req_q   <= 1'b1;
            mem_addr_q  <= {g_addr[31:4], g_start, 1'b0};
            mem_burst_q <= g_burst;
            mem_len_q   <= g_burst ? 3'd7 : 3'd0;
            line_q      <= g_addr[31:4];
            idx_q       <= g_start;
            cnt_q       <= '0;
            tmo_q       <= '0;
            win_d_q     <= grant_d;
            starve_q    <= (grant_pref && oth_req) ? starve_q + 2'd1 : 2'd0;
          end
        end
        StFetch: begin
          if (ack) begin
            fill_q[{idx_q, 4'b0000} +: 16] <= mem_data;
            idx_q <= nxt_idx;
            cnt_q <= cnt_q + 3'd1;
            tmo_q <= '0;
            if (cnt_q == 3'd7) begin
              state_q   <= StDone;
              mem_req_q <= 1'b0;
              d_valid_q <= win_d_q;
              i_valid_q <= !win_d_q;
            end else if (!mem_burst_q) begin
              state_q    <= StGap;
              mem_req_q  <= 1'b0;
              mem_addr_q <= {line_q, nxt_idx, 1'b0};
            end
          end else if (TmoEn && (tmo_q == TmoLim)) begin
            state_q   <= StErr;
            mem_req_q <= 1'b0;
            err_q     <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        StGap: begin
          state_q   <= StFetch;
          mem_req_q <= 1'b1;
        end
        StDone, StErr: begin
          state_q     <= StIdle;
          busy_q      <= 1'b0;
          mem_addr_q  <= '0;
          mem_burst_q <= 1'b0;
          mem_len_q   <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_req       = mem_req_q;
  assign mem_addr      = mem_addr_q;
  assign mem_burst     = mem_burst_q;
  assign mem_burst_len = mem_len_q;
  assign fill_data     = fill_q;
  assign i_fill_valid  = i_valid_q;
  assign d_fill_valid  = d_valid_q;
  assign fill_busy     = busy_q;
  assign fill_err      = err_q;

endmodule

// File: tb/tb_tg68k_cache_fill_ctrl.sv
// Directed self-checking bench for tg68k_cache_fill_ctrl (D_PRIORITY=1, TIMEOUT_CYC=16).
module tb_tg68k_cache_fill_ctrl;

  logic         clk = 1'b0;
  logic         nreset;
  logic         i_fill_req;
  logic [31:0]  i_fill_addr;
  logic         d_fill_req;
  logic [31:0]  d_fill_addr;
  logic         cacr_ibe;
  logic         cacr_dbe;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_burst;
  logic [2:0]   mem_burst_len;
  logic [15:0]  mem_data;
  logic         mem_ack;
  logic [127:0] fill_data;
  logic         i_fill_valid;
  logic         d_fill_valid;
  logic         fill_busy;
  logic         fill_err;

  int checks   = 0;
  int failures = 0;

  tg68k_cache_fill_ctrl #(
    .D_PRIORITY (1),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk          (clk),
    .nreset       (nreset),
    .i_fill_req   (i_fill_req),
    .i_fill_addr  (i_fill_addr),
    .d_fill_req   (d_fill_req),
    .d_fill_addr  (d_fill_addr),
    .cacr_ibe     (cacr_ibe),
    .cacr_dbe     (cacr_dbe),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_burst    (mem_burst),
    .mem_burst_len(mem_burst_len),
    .mem_data     (mem_data),
    .mem_ack      (mem_ack),
    .fill_data    (fill_data),
    .i_fill_valid (i_fill_valid),
    .d_fill_valid (d_fill_valid),
    .fill_busy    (fill_busy),
    .fill_err     (fill_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Eight back-to-back burst acks; the k-th ack carries dbase + absolute word index.
  task automatic do_acks(input logic [15:0] dbase, input int start);
    for (int k = 0; k < 8; k++) begin
      mem_ack  = 1'b1;
      mem_data = dbase + 16'((start + k) % 8);
      step();
    end
    mem_ack  = 1'b0;
    mem_data = 16'h0;
  endtask

  function automatic logic [127:0] line_of(input logic [15:0] dbase);
    logic [127:0] l;
    l = '0;
    for (int w = 0; w < 8; w++) l[w*16 +: 16] = dbase + 16'(w);
    return l;
  endfunction

  task automatic test_reset();
    nreset = 1'b0;
    step();
    step();
    checks++;
    if ({mem_req, mem_burst, mem_burst_len, i_fill_valid, d_fill_valid, fill_busy, fill_err}
        !== 9'd0) begin
      failures++;
      $display("FAIL reset_ctrl got %b exp 0", {mem_req, mem_burst, mem_burst_len,
               i_fill_valid, d_fill_valid, fill_busy, fill_err});
    end
    checks++;
    if (mem_addr !== 32'h0 || fill_data !== 128'h0) begin
      failures++;
      $display("FAIL reset_data got addr=%h data=%h exp 0", mem_addr, fill_data);
    end
    nreset = 1'b1;
    step();
  endtask

  task automatic test_dfill();
    int vcount;
    int start;
    logic [31:0] exp_addr;
`ifdef CACHE_FILL_WRAP_EN
    start    = 2;
    exp_addr = 32'h1234;
`else
    start    = 0;
    exp_addr = 32'h1230;
`endif
    d_fill_req  = 1'b1;
    d_fill_addr = 32'h1234;
    cacr_dbe    = 1'b1;
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== exp_addr || fill_busy !== 1'b1) begin
      failures++;
      $display("FAIL dfill_grant got req=%b addr=%h busy=%b exp 1 %h 1",
               mem_req, mem_addr, fill_busy, exp_addr);
    end
    checks++;
    if (mem_burst !== 1'b1 || mem_burst_len !== 3'd7) begin
      failures++;
      $display("FAIL dfill_burst got burst=%b len=%0d exp 1 7", mem_burst, mem_burst_len);
    end
    d_fill_req = 1'b0;
    vcount = 0;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) begin
        checks++;
        if (mem_addr !== exp_addr || mem_req !== 1'b1) begin
          failures++;
          $display("FAIL dfill_hold got addr=%h req=%b exp %h 1", mem_addr, mem_req, exp_addr);
        end
      end
      if (d_fill_valid) vcount++;
      mem_ack  = 1'b1;
      mem_data = 16'hA000 + 16'((start + k) % 8);
      step();
    end
    mem_ack = 1'b0;
    checks++;
    if (d_fill_valid !== 1'b1 || i_fill_valid !== 1'b0 || vcount != 0) begin
      failures++;
      $display("FAIL dfill_valid got d=%b i=%b early=%0d exp 1 0 0",
               d_fill_valid, i_fill_valid, vcount);
    end
    checks++;
    if (fill_data !== line_of(16'hA000)) begin
      failures++;
      $display("FAIL dfill_data got %h exp %h", fill_data, line_of(16'hA000));
    end
    step();
    checks++;
    if (d_fill_valid !== 1'b0 || fill_busy !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL dfill_end got valid=%b busy=%b req=%b exp 0 0 0",
               d_fill_valid, fill_busy, mem_req);
    end
    checks++;
    if (fill_data !== line_of(16'hA000)) begin
      failures++;
      $display("FAIL dfill_hold_data got %h exp %h", fill_data, line_of(16'hA000));
    end
  endtask

  task automatic test_priority();
    logic exp_d [3];
    logic is_d;
    int   waited;
    exp_d[0] = 1'b1;
    exp_d[1] = 1'b1;
    exp_d[2] = 1'b0;
    i_fill_addr = 32'h4000;
    d_fill_addr = 32'h8000;
    cacr_ibe    = 1'b1;
    cacr_dbe    = 1'b1;
    i_fill_req  = 1'b1;
    d_fill_req  = 1'b1;
    for (int r = 0; r < 3; r++) begin
      waited = 0;
      while (!mem_req && waited < 6) begin
        step();
        waited++;
      end
      checks++;
      if (mem_req !== 1'b1) begin
        failures++;
        $display("FAIL prio_grant%0d got req=%b exp 1", r, mem_req);
      end
      is_d = (mem_addr == 32'h8000);
      checks++;
      if (is_d !== exp_d[r] || (mem_addr !== 32'h8000 && mem_addr !== 32'h4000)) begin
        failures++;
        $display("FAIL prio_order%0d got addr=%h exp d=%b", r, mem_addr, exp_d[r]);
      end
      do_acks(16'h1100 * 16'(r + 1), 0);
      if (r == 2) begin
        i_fill_req = 1'b0;
        d_fill_req = 1'b0;
      end
      checks++;
      if (d_fill_valid !== exp_d[r] || i_fill_valid !== !exp_d[r]) begin
        failures++;
        $display("FAIL prio_valid%0d got d=%b i=%b exp d=%b", r, d_fill_valid, i_fill_valid,
                 exp_d[r]);
      end
      checks++;
      if (fill_data !== line_of(16'h1100 * 16'(r + 1))) begin
        failures++;
        $display("FAIL prio_data%0d got %h", r, fill_data);
      end
    end
    step();
    step();
    step();
    checks++;
    if (mem_req !== 1'b0 || fill_busy !== 1'b0) begin
      failures++;
      $display("FAIL prio_idle got req=%b busy=%b exp 0 0", mem_req, fill_busy);
    end
  endtask

  task automatic test_single();
    i_fill_req  = 1'b1;
    i_fill_addr = 32'h100;
    cacr_ibe    = 1'b0;
    step();
    i_fill_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h100 + 32'(2 * k) || mem_burst !== 1'b0 ||
          mem_burst_len !== 3'd0) begin
        failures++;
        $display("FAIL single_req%0d got req=%b addr=%h burst=%b len=%0d exp 1 %h 0 0",
                 k, mem_req, mem_addr, mem_burst, mem_burst_len, 32'h100 + 32'(2 * k));
      end
      mem_ack  = 1'b1;
      mem_data = 16'hB000 + 16'(k);
      step();
      if (k < 7) begin
        // Stray ack during the gap must be dropped.
        mem_data = 16'hDEAD;
        checks++;
        if (mem_req !== 1'b0 || i_fill_valid !== 1'b0) begin
          failures++;
          $display("FAIL single_gap%0d got req=%b valid=%b exp 0 0", k, mem_req, i_fill_valid);
        end
        step();
        mem_ack = 1'b0;
      end
    end
    mem_ack = 1'b0;
    checks++;
    if (i_fill_valid !== 1'b1 || fill_data !== line_of(16'hB000)) begin
      failures++;
      $display("FAIL single_done got valid=%b data=%h exp 1 %h", i_fill_valid, fill_data,
               line_of(16'hB000));
    end
    step();
  endtask

`ifdef CACHE_FILL_WRAP_EN
  task automatic test_wrap();
    d_fill_req  = 1'b1;
    d_fill_addr = 32'h20A;
    cacr_dbe    = 1'b1;
    step();
    d_fill_req = 1'b0;
    checks++;
    if (mem_addr !== 32'h20A || mem_req !== 1'b1) begin
      failures++;
      $display("FAIL wrap_addr got %h req=%b exp 20a 1", mem_addr, mem_req);
    end
    do_acks(16'hC000, 5);
    checks++;
    if (d_fill_valid !== 1'b1 || fill_data !== line_of(16'hC000)) begin
      failures++;
      $display("FAIL wrap_data got valid=%b data=%h exp 1 %h", d_fill_valid, fill_data,
               line_of(16'hC000));
    end
    step();
  endtask
`endif

  task automatic test_timeout();
    int first;
    int errs;
    int vp;
    i_fill_req  = 1'b1;
    i_fill_addr = 32'h300;
    cacr_ibe    = 1'b1;
    step();
    i_fill_req = 1'b0;
    first = -1;
    errs  = 0;
    vp    = 0;
    for (int t = 1; t <= 30; t++) begin
      step();
      if (fill_err) begin
        errs++;
        if (first < 0) first = t;
        checks++;
        if (mem_req !== 1'b0) begin
          failures++;
          $display("FAIL tmo_req got %b exp 0", mem_req);
        end
      end
      if (i_fill_valid || d_fill_valid) vp++;
    end
    checks++;
    if (first != 17 || errs != 1 || vp != 0) begin
      failures++;
      $display("FAIL tmo_err got first=%0d pulses=%0d valids=%0d exp 17 1 0", first, errs, vp);
    end
    d_fill_req  = 1'b1;
    d_fill_addr = 32'h500;
    cacr_dbe    = 1'b1;
    step();
    d_fill_req = 1'b0;
    do_acks(16'hD000, 0);
    checks++;
    if (d_fill_valid !== 1'b1 || fill_data !== line_of(16'hD000) || fill_err !== 1'b0) begin
      failures++;
      $display("FAIL tmo_recover got valid=%b err=%b data=%h", d_fill_valid, fill_err,
               fill_data);
    end
    step();
  endtask

  task automatic test_reset_midfill();
    int pulses;
    d_fill_req  = 1'b1;
    d_fill_addr = 32'h600;
    cacr_dbe    = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      mem_ack  = 1'b1;
      mem_data = 16'hE000 + 16'(k);
      step();
    end
    mem_ack    = 1'b0;
    d_fill_req = 1'b0;
    nreset     = 1'b0;
    step();
    checks++;
    if ({mem_req, mem_burst, mem_burst_len, i_fill_valid, d_fill_valid, fill_busy, fill_err}
        !== 9'd0 || mem_addr !== 32'h0 || fill_data !== 128'h0) begin
      failures++;
      $display("FAIL rst_mid got req=%b busy=%b addr=%h data=%h exp all 0",
               mem_req, fill_busy, mem_addr, fill_data);
    end
    nreset = 1'b1;
    pulses = 0;
    for (int t = 0; t < 4; t++) begin
      step();
      if (i_fill_valid || d_fill_valid || fill_err || mem_req) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL rst_quiet got %0d active cycles exp 0", pulses);
    end
    i_fill_req  = 1'b1;
    i_fill_addr = 32'h700;
    cacr_ibe    = 1'b1;
    step();
    i_fill_req = 1'b0;
    do_acks(16'hF000, 0);
    checks++;
    if (i_fill_valid !== 1'b1 || fill_data !== line_of(16'hF000)) begin
      failures++;
      $display("FAIL rst_refill got valid=%b data=%h exp 1 %h", i_fill_valid, fill_data,
               line_of(16'hF000));
    end
    step();
  endtask

  initial begin
    nreset      = 1'b0;
    i_fill_req  = 1'b0;
    i_fill_addr = 32'h0;
    d_fill_req  = 1'b0;
    d_fill_addr = 32'h0;
    cacr_ibe    = 1'b0;
    cacr_dbe    = 1'b0;
    mem_data    = 16'h0;
    mem_ack     = 1'b0;
    test_reset();
    test_dfill();
    test_priority();
    test_single();
`ifdef CACHE_FILL_WRAP_EN
    test_wrap();
`endif
    test_timeout();
    test_reset_midfill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
